jh_spram_arbiter: RTL and testbench

//  Shares one jh_external_single_port_RAM instance between NUM_REQ requesters.

---
 rtl/jh_spram_pkg.sv | 11 +
 rtl/jh_rr_arbiter.sv | 45 ++++
 rtl/jh_spram_arbiter.sv | 102 ++++++++++
 tb/tb_jh_spram_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jh_spram_pkg.sv
// Shared definitions for the single-port RAM arbiter: read latency and index width helper.
package jh_spram_pkg;

  localparam int RD_LATENCY = 2;

  // Width of a requester index; never below one bit so single-bit fields stay legal.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/jh_rr_arbiter.sv
// Round-robin grant picker with an optional sticky owner; purely combinational.
module jh_rr_arbiter
  import jh_spram_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int LB_NUM_REQ = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]    req,
  input  logic [LB_NUM_REQ-1:0] ptr,
  input  logic                  lock_active,
  input  logic [LB_NUM_REQ-1:0] lock_owner,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [LB_NUM_REQ-1:0] gnt_idx
);

  always_comb begin
    int k;
    logic found;
    logic [LB_NUM_REQ-1:0] kk;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    kk      = '0;
    if (lock_active) begin
      // Owner keeps the bank even while idle; everyone else waits.
      if (req[lock_owner]) begin
        gnt[lock_owner] = 1'b1;
        gnt_idx         = lock_owner;
      end
    end else begin
      for (int off = 0; off < NUM_REQ; off++) begin
        k = int'(ptr) + off;
        if (k >= NUM_REQ) k = k - NUM_REQ;
        kk = LB_NUM_REQ'(k);
        if (!found && req[kk]) begin
          found   = 1'b1;
          gnt[kk] = 1'b1;
          gnt_idx = kk;
        end
      end
    end
  end

endmodule

// File: rtl/jh_spram_arbiter.sv
// Shares one registered single-port RAM between NUM_REQ requesters, one op per cycle,
// routing read data back through a fixed-latency tag pipeline.
module jh_spram_arbiter
  import jh_spram_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 256,
  localparam int LB_RAM_DEPTH = $clog2(RAM_DEPTH),
  localparam int LB_NUM_REQ   = idx_width(NUM_REQ)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ-1:0]                    req_we,
  input  logic [NUM_REQ-1:0]                    req_lock,
  input  logic [NUM_REQ-1:0][LB_RAM_DEPTH-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [DATA_WIDTH-1:0]                 rsp_data,
  output logic [LB_RAM_DEPTH-1:0]               ram_addr,
  output logic [DATA_WIDTH-1:0]                 ram_din,
  output logic                                  ram_wr_en,
  input  logic [DATA_WIDTH-1:0]                 ram_dout,
  output logic [LB_NUM_REQ-1:0]                 grant_id
);

  typedef struct packed {
    logic                  vld;
    logic [LB_NUM_REQ-1:0] id;
  } rd_tag_t;

  logic [LB_NUM_REQ-1:0]   rr_ptr;
  logic [LB_NUM_REQ-1:0]   lock_owner;
  logic                    lock_active;
  logic [NUM_REQ-1:0]      gnt;
  logic [LB_NUM_REQ-1:0]   gnt_idx;
  logic [LB_NUM_REQ-1:0]   next_ptr;
  logic                    any_gnt;
  logic [LB_RAM_DEPTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]   din_q;
  rd_tag_t                 tag_in;
  rd_tag_t                 tag_pipe [RD_LATENCY];

  jh_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .lock_active (lock_active),
    .lock_owner  (lock_owner),
    .gnt         (gnt),
    .gnt_idx     (gnt_idx)
  );

  assign req_ready = rst ? '0 : gnt;
  assign any_gnt   = |req_ready;
  assign grant_id  = gnt_idx;

  // Address and data hold their last value on idle cycles to avoid needless RAM pin toggling.
  assign ram_wr_en = any_gnt & req_we[gnt_idx];
  assign ram_addr  = any_gnt ? req_addr[gnt_idx]  : addr_q;
  assign ram_din   = any_gnt ? req_wdata[gnt_idx] : din_q;

  assign next_ptr = (gnt_idx == LB_NUM_REQ'(NUM_REQ - 1)) ? '0 : gnt_idx + LB_NUM_REQ'(1);

  assign tag_in.vld = any_gnt & ~req_we[gnt_idx];
  assign tag_in.id  = gnt_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      lock_active <= 1'b0;
      lock_owner  <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      if (any_gnt) begin
        addr_q <= ram_addr;
        din_q  <= ram_din;
        if (req_lock[gnt_idx]) begin
          lock_active <= 1'b1;
          lock_owner  <= gnt_idx;
        end else begin
          lock_active <= 1'b0;
          rr_ptr      <= next_ptr;
        end
      end
      tag_pipe[0] <= tag_in;
      for (int i = 1; i < RD_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  // Response data comes straight from the RAM output register; only the strobe is ours.
  always_comb begin
    rsp_valid = '0;
    if (tag_pipe[RD_LATENCY-1].vld) rsp_valid[tag_pipe[RD_LATENCY-1].id] = 1'b1;
  end

  assign rsp_data = ram_dout;

endmodule

// File: tb/tb_jh_spram_arbiter.sv
// Bench for jh_spram_arbiter: behavioural RAM behind the arbiter, directed scenarios plus random traffic.
module tb_jh_spram_arbiter;

  localparam int N     = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int IW    = 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][DW-1:0] req_wdata;
  logic [DW-1:0]        rsp_data, ram_din, ram_dout;
  logic [AW-1:0]        ram_addr;
  logic                 ram_wr_en;
  logic [IW-1:0]        grant_id;

  always #5 clk = ~clk;

  jh_spram_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .RAM_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_wr_en (ram_wr_en),
    .ram_dout  (ram_dout),
    .grant_id  (grant_id)
  );

  // Single-port RAM with registered inputs and registered output, no reset.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ram_a_q;
  logic [DW-1:0] ram_d_q;
  logic          ram_we_q;

  always @(posedge clk) begin
    ram_a_q  <= ram_addr;
    ram_d_q  <= ram_din;
    ram_we_q <= ram_wr_en;
    if (ram_we_q) mem[ram_a_q] <= ram_d_q;
    ram_dout <= mem[ram_a_q];
  end

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } exp_rsp_t;

  exp_rsp_t      rsp_q[$];
  logic [DW-1:0] m_mem [DEPTH];
  int            m_ptr, m_owner, m_gnt, cyc;
  bit            m_lock;
  int            checks, failures;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic bit valid_of(input int i);
    logic [N-1:0] t;
    t = req_valid >> i;
    return t[0];
  endfunction

  // Reference grant: owner-only while locked, else first valid from the pointer, wrapping.
  function automatic int model_pick();
    if (rst) return -1;
    if (m_lock) return valid_of(m_owner) ? m_owner : -1;
    for (int off = 0; off < N; off++)
      if (valid_of((m_ptr + off) % N)) return (m_ptr + off) % N;
    return -1;
  endfunction

  task automatic check_outputs();
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    m_gnt   = model_pick();
    exp_rdy = '0;
    if (m_gnt >= 0) exp_rdy[IW'(m_gnt)] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (m_gnt >= 0) begin
      chk("grant_id", 32'(grant_id), 32'(m_gnt));
      chk("ram_wr_en", 32'(ram_wr_en), 32'(req_we[IW'(m_gnt)]));
      chk("ram_addr", 32'(ram_addr), 32'(req_addr[IW'(m_gnt)]));
      if (req_we[IW'(m_gnt)]) chk("ram_din", 32'(ram_din), 32'(req_wdata[IW'(m_gnt)]));
    end else begin
      chk("ram_wr_en_idle", 32'(ram_wr_en), 32'd0);
    end
    exp_rv = '0;
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      exp_rv[IW'(rsp_q[0].id)] = 1'b1;
      chk("rsp_data", 32'(rsp_data), 32'(rsp_q[0].data));
      void'(rsp_q.pop_front());
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
  endtask

  task automatic model_update();
    if (rst) begin
      m_ptr  = 0;
      m_lock = 1'b0;
      rsp_q.delete();
    end else if (m_gnt >= 0) begin
      if (req_we[IW'(m_gnt)])
        m_mem[req_addr[IW'(m_gnt)]] = req_wdata[IW'(m_gnt)];
      else
        rsp_q.push_back('{due: cyc + 2, id: m_gnt, data: m_mem[req_addr[IW'(m_gnt)]]});
      if (req_lock[IW'(m_gnt)]) begin
        m_lock  = 1'b1;
        m_owner = m_gnt;
      end else begin
        m_lock = 1'b0;
        m_ptr  = (m_gnt + 1) % N;
      end
    end
    cyc++;
  endtask

  task automatic run_cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic drive(input int i, input bit we, input bit lk, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    req_valid[IW'(i)] = 1'b1;
    req_we[IW'(i)]    = we;
    req_lock[IW'(i)]  = lk;
    req_addr[IW'(i)]  = a;
    req_wdata[IW'(i)] = d;
  endtask

  task automatic drain(input int n);
    idle();
    for (int k = 0; k < n; k++) run_cycle();
  endtask

  // Requesters stay valid through reset so a stray ready would show up.
  task automatic do_reset();
    idle();
    req_valid = '1;
    rst = 1'b1;
    run_cycle();
    run_cycle();
    rst = 1'b0;
    idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    m_ptr    = 0;
    m_owner  = 0;
    m_gnt    = -1;
    m_lock   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]   = '0;
      m_mem[i] = '0;
    end
    idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Write then read the same address back to back.
    drive(0, 1'b1, 1'b0, 8'h10, 8'hA5);
    run_cycle();
    idle(); drive(0, 1'b0, 1'b0, 8'h10, 8'h00);
    run_cycle();
    idle();
    run_cycle();
    #1;
    chk("s1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("s1_rsp_data", 32'(rsp_data), 32'hA5);
    run_cycle();
    drain(2);

    // Two persistent readers alternate.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      idle();
      drive(0, 1'b0, 1'b0, 8'h01, 8'h00);
      drive(1, 1'b0, 1'b0, 8'h02, 8'h00);
      #1;
      chk("s2_order", 32'(grant_id), 32'(k % 2));
      run_cycle();
    end
    drain(3);

    // Requester 1 holds a lock for three beats, including an idle gap.
    do_reset();
    drive(1, 1'b0, 1'b1, 8'h05, 8'h00);
    run_cycle();
    idle(); drive(0, 1'b0, 1'b0, 8'h03, 8'h00); drive(1, 1'b0, 1'b1, 8'h06, 8'h00);
    #1;
    chk("s3_hold", 32'(req_ready), 32'd2);
    run_cycle();
    idle(); drive(0, 1'b0, 1'b0, 8'h03, 8'h00);
    #1;
    chk("s3_stall", 32'(req_ready), 32'd0);
    run_cycle();
    idle(); drive(0, 1'b0, 1'b0, 8'h03, 8'h00); drive(1, 1'b0, 1'b0, 8'h07, 8'h00);
    run_cycle();
    idle(); drive(0, 1'b0, 1'b0, 8'h03, 8'h00);
    #1;
    chk("s3_release", 32'(req_ready), 32'd1);
    run_cycle();
    drain(3);

    // Top address, then an untouched word.
    idle(); drive(0, 1'b1, 1'b0, 8'hFF, 8'h3C);
    run_cycle();
    idle(); drive(0, 1'b0, 1'b0, 8'hFF, 8'h00);
    run_cycle();
    idle(); drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    run_cycle();
    idle();
    #1;
    chk("s4_top", 32'(rsp_data), 32'h3C);
    run_cycle();
    #1;
    chk("s4_zero", 32'(rsp_data), 32'h00);
    chk("s4_zero_vld", 32'(rsp_valid), 32'd1);
    run_cycle();
    drain(2);

    // Reset while a read is in flight; the earlier write must survive.
    do_reset();
    drive(0, 1'b1, 1'b0, 8'h20, 8'h77);
    run_cycle();
    idle(); drive(1, 1'b0, 1'b0, 8'h20, 8'h00);
    run_cycle();
    idle(); rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    idle();
    #1;
    chk("s5_no_rsp", 32'(rsp_valid), 32'd0);
    run_cycle();
    drive(0, 1'b0, 1'b0, 8'h20, 8'h00);
    run_cycle();
    idle();
    run_cycle();
    #1;
    chk("s5_kept", 32'(rsp_data), 32'h77);
    chk("s5_kept_vld", 32'(rsp_valid), 32'd1);
    run_cycle();
    drain(2);

    // Single-requester stream.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      idle(); drive(0, 1'b1, 1'b0, AW'(8'h40 + k), DW'($urandom));
      run_cycle();
    end
    for (int k = 0; k < 8; k++) begin
      idle(); drive(0, 1'b0, 1'b0, AW'(8'h40 + k), 8'h00);
      #1;
      chk("s6_ready", 32'(req_ready), 32'd1);
      run_cycle();
    end
    drain(3);

    // Random mixed traffic on a small address window to force collisions.
    for (int c = 0; c < 600; c++) begin
      idle();
      for (int i = 0; i < N; i++)
        if ($urandom_range(3) != 0)
          drive(i, 1'($urandom_range(1)), $urandom_range(4) == 0,
                AW'($urandom_range(15)), DW'($urandom));
      run_cycle();
    end
    drain(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
